// File: rtl/sd_wb_sequencer.sv
// SD controller Wishbone sequencer: runs a micro-op program from an external op ROM
// (write, read, poll, wait, jump, halt) with bus/poll timeouts, abort and error reporting.
module sd_wb_sequencer #(
    parameter int PC_W        = 5,
    parameter int BUS_TIMEOUT = 255,
    parameter int POLL_LIMIT  = 1023,
    parameter int POLL_GAP    = 15
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            start_i,
    input  logic [PC_W-1:0] start_pc_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [2:0]      err_code_o,
    output logic [PC_W-1:0] pc_o,
    output logic [31:0]     rd_data_o,
    output logic            rd_valid_o,
    output logic [PC_W-1:0] op_addr_o,
    input  logic [42:0]     op_data_i,
    output logic [7:0]      sdc_wb_adr_o,
    output logic [31:0]     sdc_wb_dat_o,
    input  logic [31:0]     sdc_wb_dat_i,
    output logic [3:0]      sdc_wb_sel_o,
    output logic            sdc_wb_we_o,
    output logic            sdc_wb_cyc_o,
    output logic            sdc_wb_stb_o,
    input  logic            sdc_wb_ack_i,
    input  logic            sdc_wb_err_i
);
    localparam int PCNT_W = $clog2(POLL_LIMIT + 1);
    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_BUS, S_WAIT, S_GAP} state_t;
    typedef enum logic [2:0] {
        OP_HALT, OP_WRITE, OP_READ, OP_POLL_SET, OP_POLL_CLR, OP_WAIT, OP_JUMP, OP_ILLEGAL
    } opcode_t;

    state_t              state_q, state_d;
    opcode_t             op_q, op_d, dec_op;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [2:0]          code_q, code_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [7:0]          adr_q, adr_d;
    logic [31:0]         dat_q, dat_d, mask_q, mask_d;
    logic [PCNT_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic [7:0]          bus_cnt_q, bus_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [31:0]         wait_cnt_q, wait_cnt_d;
    logic                fail, poll_hit;
    logic [2:0]          fail_code;

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_code_o   = code_q;
    assign pc_o         = pc_q;
    assign op_addr_o    = pc_q;
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign sdc_wb_adr_o = adr_q;
    assign sdc_wb_dat_o = dat_q;
    assign sdc_wb_sel_o = 4'b1111;
    assign sdc_wb_we_o  = we_q;
    assign sdc_wb_cyc_o = cyc_q;
    assign sdc_wb_stb_o = stb_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            op_q       <= OP_HALT;
            pc_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 3'd0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            mask_q     <= '0;
            poll_cnt_q <= '0;
            bus_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            pc_q       <= pc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            mask_q     <= mask_d;
            poll_cnt_q <= poll_cnt_d;
            bus_cnt_q  <= bus_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pc_d       = pc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        code_d     = code_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        mask_d     = mask_q;
        poll_cnt_d = poll_cnt_q;
        bus_cnt_d  = bus_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        wait_cnt_d = wait_cnt_q;
        fail       = 1'b0;
        fail_code  = 3'd0;
        dec_op     = opcode_t'(op_data_i[42:40]);
        poll_hit   = (op_q == OP_POLL_SET) ? |(sdc_wb_dat_i & mask_q)
                                           : ~|(sdc_wb_dat_i & mask_q);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pc_d    = start_pc_i;
                    err_d   = 1'b0;
                    code_d  = 3'd0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                poll_cnt_d = '0;
                op_d       = dec_op;
                mask_d     = op_data_i[31:0];
                case (dec_op)
                    OP_HALT: begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                    OP_WRITE, OP_READ, OP_POLL_SET, OP_POLL_CLR: begin
                        cyc_d     = 1'b1;
                        stb_d     = 1'b1;
                        we_d      = (dec_op == OP_WRITE);
                        adr_d     = op_data_i[39:32];
                        dat_d     = (dec_op == OP_WRITE) ? op_data_i[31:0] : 32'd0;
                        bus_cnt_d = '0;
                        state_d   = S_BUS;
                    end
                    OP_WAIT: begin
                        if (op_data_i[31:0] == 32'd0) begin
                            pc_d    = pc_q + 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            wait_cnt_d = op_data_i[31:0];
                            state_d    = S_WAIT;
                        end
                    end
                    OP_JUMP: begin
                        pc_d    = op_data_i[PC_W-1:0];
                        state_d = S_FETCH;
                    end
                    default: begin
                        fail      = 1'b1;
                        fail_code = 3'd4;
                    end
                endcase
            end
            S_BUS: begin
                // err_i beats a simultaneous ack_i; the timeout only fires with no termination at all
                if (sdc_wb_err_i) begin
                    fail      = 1'b1;
                    fail_code = 3'd1;
                end else if (sdc_wb_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    case (op_q)
                        OP_WRITE: begin
                            pc_d    = pc_q + 1'b1;
                            state_d = S_FETCH;
                        end
                        OP_READ: begin
                            rd_data_d  = sdc_wb_dat_i;
                            rd_valid_d = 1'b1;
                            pc_d       = pc_q + 1'b1;
                            state_d    = S_FETCH;
                        end
                        default: begin
                            rd_data_d = sdc_wb_dat_i;
                            if (poll_hit) begin
                                pc_d    = pc_q + 1'b1;
                                state_d = S_FETCH;
                            end else if (poll_cnt_q == PCNT_W'(POLL_LIMIT)) begin
                                fail      = 1'b1;
                                fail_code = 3'd3;
                            end else begin
                                poll_cnt_d = poll_cnt_q + 1'b1;
                                gap_cnt_d  = GAP_W'(POLL_GAP);
                                state_d    = S_GAP;
                            end
                        end
                    endcase
                end else if (bus_cnt_q == 8'(BUS_TIMEOUT - 1)) begin
                    fail      = 1'b1;
                    fail_code = 3'd2;
                end else begin
                    bus_cnt_d = bus_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q <= 32'd1) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    bus_cnt_d = '0;
                    state_d   = S_BUS;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever the current state decided; the returned data is discarded
        if (state_q != S_IDLE && abort_i) begin
            fail      = 1'b1;
            fail_code = 3'd5;
            rd_data_d = rd_data_q;
        end

        if (fail) begin
            err_d      = 1'b1;
            code_d     = fail_code;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            cyc_d      = 1'b0;
            stb_d      = 1'b0;
            we_d       = 1'b0;
            rd_valid_d = 1'b0;
            pc_d       = pc_q;
            state_d    = S_IDLE;
        end
    end
endmodule
